// File: rtl/tdc_io_pkg.sv
// Shared types and constants for the character-output UART path.
package tdc_io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/char_out_uart_tx_if.sv
// Push/pop channel between the UART transmitter and its byte FIFO.
// Handshake: push is a request qualified by full (dropped when full),
// pop is a request qualified by empty; both take effect on the clock edge.
interface char_out_uart_tx_if #(
    parameter int ADDR_W = 4
);
    import tdc_io_pkg::*;

    logic                      push;
    logic [UART_DATA_BITS-1:0] wdata;
    logic                      pop;
    logic [UART_DATA_BITS-1:0] rdata;
    logic                      full;
    logic                      empty;
    logic                      drop;
    logic [ADDR_W:0]           count;

    modport master (
        output push, wdata, pop,
        input  rdata, full, empty, drop, count
    );

    modport slave (
        input  push, wdata, pop,
        output rdata, full, empty, drop, count
    );

endinterface

// File: rtl/char_out_uart_tx_byte_fifo.sv
// Single-clock byte FIFO; a push while full is discarded and flagged on drop,
// judged on the pre-edge count even if a pop happens on the same edge.
module char_out_uart_tx_byte_fifo
    import tdc_io_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic clock,
    input  logic reset,
    char_out_uart_tx_if.slave fif
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]           count_q, count_d;
    logic                      do_push, do_pop;

    assign fif.full  = (count_q == CNT_DEPTH);
    assign fif.empty = (count_q == '0);
    assign fif.count = count_q;
    assign fif.rdata = mem_q[rd_ptr_q];
    assign fif.drop  = fif.push & fif.full;

    assign do_push = fif.push & ~fif.full;
    assign do_pop  = fif.pop & ~fif.empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= fif.wdata;
    end

endmodule

// File: rtl/char_out_uart_tx.sv
// Buffers character-output strobes and sends them as UART 8N1, LSB first,
// with frames back to back while bytes are queued; drops set a sticky flag.
module char_out_uart_tx
    import tdc_io_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      out_en,
    input  logic [UART_DATA_BITS-1:0] out_data,
    output logic                      tx,
    output logic                      busy,
    output logic                      fifo_full,
    output logic                      overflow,
    output tx_state_e                 dbg_state
);

    localparam int             CW       = $clog2(CLOCKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_MAX = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0]  BAUD_ONE = CW'(1);

    char_out_uart_tx_if #(.ADDR_W(FIFO_ADDR_WIDTH)) fif ();

    tx_state_e                 state_q, state_d;
    logic [CW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      overflow_q;
    logic                      pop;
    logic                      baud_last;

    char_out_uart_tx_byte_fifo #(.ADDR_W(FIFO_ADDR_WIDTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .fif   (fif.slave)
    );

    assign fif.push  = out_en;
    assign fif.wdata = out_data;
    assign fif.pop   = pop;

    assign baud_last = (baud_q == BAUD_MAX);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = UART_IDLE_LEVEL;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fif.empty) begin
                    pop     = 1'b1;
                    shift_d = fif.rdata;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                tx_d = UART_IDLE_LEVEL;
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!fif.empty) begin
                        pop     = 1'b1;
                        shift_d = fif.rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_q | fif.drop;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != IDLE) || (fif.count != '0);
    assign fifo_full = fif.full;
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_char_out_uart_tx.sv
// Directed bench for char_out_uart_tx with a UART receive monitor and byte scoreboard.
module tb_char_out_uart_tx;
  import tdc_io_pkg::*;

  localparam int CPB   = 4;
  localparam int FAW   = 2;
  localparam int FRAME = 10 * CPB;

  logic      clock = 1'b0;
  logic      reset = 1'b1;
  logic      tx, busy, fifo_full, overflow;
  tx_state_e dbg_state;

  char_out_uart_tx_if #(.ADDR_W(FAW)) drv ();

  char_out_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(FAW)) dut (
    .clock     (clock),
    .reset     (reset),
    .out_en    (drv.push),
    .out_data  (drv.wdata),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d, input bit accepted);
    drv.push  = 1'b1;
    drv.wdata = d;
    if (accepted) exp_q.push_back(d);
    tick();
    drv.push  = 1'b0;
    drv.wdata = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    check_vec(tag, 64'(busy), 64'd0);
  endtask

  // Records tx and busy for one frame's worth of cycles, one sample per cycle.
  task automatic capture(output logic [FRAME-1:0] v, output logic [FRAME-1:0] bz);
    for (int j = 0; j < FRAME; j++) begin
      v[j]  = tx;
      bz[j] = busy;
      tick();
    end
  endtask

  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] d);
    logic [FRAME-1:0] f;
    for (int j = 0; j < FRAME; j++) begin
      int slot = j / CPB;
      if (slot == 0)      f[j] = 1'b0;
      else if (slot == 9) f[j] = 1'b1;
      else                f[j] = d[slot-1];
    end
    return f;
  endfunction

  // UART monitor + scoreboard: samples mid-bit on the falling edge.
  bit         mon_active = 1'b0;
  int         mon_phase  = 0;
  logic [7:0] mon_byte   = '0;

  always @(negedge clock) begin
    if (reset) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (tx == 1'b0) begin
        mon_active <= 1'b1;
        mon_phase  <= 1;
      end
    end else begin
      mon_phase <= mon_phase + 1;
      if (mon_phase == CPB/2)
        check_vec("mon_start", 64'(tx), 64'd0);
      if (mon_phase >= CPB/2 + CPB && mon_phase < CPB/2 + 9*CPB && (mon_phase - CPB/2) % CPB == 0)
        mon_byte[(mon_phase - CPB/2) / CPB - 1] <= tx;
      if (mon_phase == CPB/2 + 9*CPB) begin
        mon_active <= 1'b0;
        check_vec("mon_stop", 64'(tx), 64'd1);
        if (exp_q.size() > 0) check_vec("mon_byte", 64'(mon_byte), 64'(exp_q.pop_front()));
        else                  check_vec("mon_byte_unexpected", 64'(mon_byte), 64'h1FF);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME-1:0] v, bz;
    bit               all_high, any_busy, any_full;

    drv.push  = 1'b0;
    drv.wdata = 8'h00;
    drv.pop   = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check_vec("rst_tx", 64'(tx), 64'd1);
    check_vec("rst_busy", 64'(busy), 64'd0);
    check_vec("rst_full", 64'(fifo_full), 64'd0);
    check_vec("rst_ovf", 64'(overflow), 64'd0);
    check_vec("rst_state", 64'(dbg_state), 64'(IDLE));

    // single byte 0x41: tx low from edge N+2, busy drops after edge N+41
    strobe(8'h41, 1'b1);
    check_vec("t1_busy_n", 64'(busy), 64'd1);
    check_vec("t1_tx_n", 64'(tx), 64'd1);
    tick();
    check_vec("t1_tx_n1", 64'(tx), 64'd1);
    check_vec("t1_state_n1", 64'(dbg_state), 64'(START));
    tick();
    capture(v, bz);
    check_vec("t1_frame", 64'(v), 64'(frame_bits(8'h41)));
    check_vec("t1_busy_n40", 64'(bz[FRAME-2]), 64'd1);
    check_vec("t1_busy_n41", 64'(bz[FRAME-1]), 64'd0);
    check_vec("t1_ovf", 64'(overflow), 64'd0);

    // back-to-back frames with no idle gap
    strobe(8'h55, 1'b1);
    strobe(8'hAA, 1'b1);
    strobe(8'h0F, 1'b1);
    capture(v, bz);
    check_vec("t2_frame0", 64'(v), 64'(frame_bits(8'h55)));
    capture(v, bz);
    check_vec("t2_frame1", 64'(v), 64'(frame_bits(8'hAA)));
    capture(v, bz);
    check_vec("t2_frame2", 64'(v), 64'(frame_bits(8'h0F)));
    check_vec("t2_busy_last", 64'(bz[FRAME-2]), 64'd1);
    check_vec("t2_busy_end", 64'(bz[FRAME-1]), 64'd0);

    // overflow with depth 4: 0x15 dropped at edge 5
    do_reset();
    for (int i = 0; i < 6; i++) begin
      strobe(8'(8'h10 + i), i < 5);
      if (i == 3) check_vec("t3_full_e3", 64'(fifo_full), 64'd0);
      if (i == 4) begin
        check_vec("t3_full_e4", 64'(fifo_full), 64'd1);
        check_vec("t3_ovf_e4", 64'(overflow), 64'd0);
      end
      if (i == 5) check_vec("t3_ovf_e5", 64'(overflow), 64'd1);
    end
    wait_idle("t3_idle", 6 * FRAME);
    check_vec("t3_ovf_sticky", 64'(overflow), 64'd1);
    check_vec("t3_q_drained", 64'(exp_q.size()), 64'd0);

    // full FIFO with a strobe on the end-of-STOP pop edge
    do_reset();
    check_vec("t4_ovf_rst", 64'(overflow), 64'd0);
    strobe(8'hA0, 1'b1);
    for (int i = 1; i <= 4; i++) strobe(8'(8'hA0 + i), 1'b1);
    check_vec("t4_full_n4", 64'(fifo_full), 64'd1);
    repeat (36) tick();
    check_vec("t4_state_n40", 64'(dbg_state), 64'(STOP));
    check_vec("t4_full_n40", 64'(fifo_full), 64'd1);
    check_vec("t4_ovf_n40", 64'(overflow), 64'd0);
    strobe(8'hB5, 1'b0);
    check_vec("t4_ovf_n41", 64'(overflow), 64'd1);
    check_vec("t4_full_n41", 64'(fifo_full), 64'd0);
    check_vec("t4_state_n41", 64'(dbg_state), 64'(START));
    wait_idle("t4_idle", 5 * FRAME);
    check_vec("t4_q_drained", 64'(exp_q.size()), 64'd0);

    // reset during DATA bit 3 with two bytes queued
    do_reset();
    strobe(8'hC3, 1'b0);
    strobe(8'hC4, 1'b0);
    strobe(8'hC5, 1'b0);
    repeat (15) tick();
    check_vec("t5_state_pre", 64'(dbg_state), 64'(DATA));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_vec("t5_tx", 64'(tx), 64'd1);
    check_vec("t5_busy", 64'(busy), 64'd0);
    check_vec("t5_full", 64'(fifo_full), 64'd0);
    check_vec("t5_ovf", 64'(overflow), 64'd0);
    all_high = 1'b1;
    any_busy = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      all_high &= tx;
      any_busy |= busy;
    end
    check_vec("t5_tx_quiet", 64'(all_high), 64'd1);
    check_vec("t5_busy_quiet", 64'(any_busy), 64'd0);

    // data noise with out_en low
    all_high = 1'b1;
    any_busy = 1'b0;
    any_full = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drv.push  = 1'b0;
      drv.wdata = 8'($urandom_range(0, 255));
      tick();
      all_high &= tx;
      any_busy |= busy;
      any_full |= fifo_full;
    end
    check_vec("t6_tx_high", 64'(all_high), 64'd1);
    check_vec("t6_busy", 64'(any_busy), 64'd0);
    check_vec("t6_full", 64'(any_full), 64'd0);

    repeat (2) tick();
    check_vec("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
